// File: rtl/a_inv_apply_pkg.sv
// Shared definitions for the 2x2 inverse-matrix apply block.
// Contents:
//   - datapath widths (coefficient, vector, product and sum widths)
//   - default number of coefficient fractional bits
//   - controller state encoding
//   - coefficient-set struct
//   - helpers: widening signed multiply and 32-bit saturation
package a_inv_apply_pkg;

    localparam int unsigned COEF_W        = 64;
    localparam int unsigned VEC_W         = 32;
    localparam int unsigned PROD_W        = 96;
    localparam int unsigned SUM_W         = 97;
    localparam int unsigned CNT_W         = 16;
    localparam int unsigned COEF_FRAC_DEF = 32;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    typedef struct packed {
        logic [COEF_W-1:0] a11;
        logic [COEF_W-1:0] a12;
        logic [COEF_W-1:0] a21;
        logic [COEF_W-1:0] a22;
    } coef_t;

    // Full signed product of a 64-bit coefficient and a 32-bit sample.
    // Both operands are sign-extended to the product width, so the low
    // PROD_W bits of the product are exact.
    function automatic logic [PROD_W-1:0] mul_cv(input logic [COEF_W-1:0] c,
                                                 input logic [VEC_W-1:0]  v);
        logic signed [PROD_W-1:0] c_ext;
        logic signed [PROD_W-1:0] v_ext;
        c_ext = $signed({{(PROD_W-COEF_W){c[COEF_W-1]}}, c});
        v_ext = $signed({{(PROD_W-VEC_W){v[VEC_W-1]}}, v});
        return c_ext * v_ext;
    endfunction

    // Clamp a wide signed value to the signed 32-bit range.
    function automatic logic [VEC_W-1:0] sat_vec(input logic signed [SUM_W-1:0] v);
        logic signed [SUM_W-1:0] max_v;
        logic signed [SUM_W-1:0] min_v;
        max_v = 97'sd2147483647;
        min_v = -97'sd2147483648;
        if (v > max_v) begin
            return 32'h7FFF_FFFF;
        end else if (v < min_v) begin
            return 32'h8000_0000;
        end else begin
            return v[VEC_W-1:0];
        end
    endfunction

endpackage

// File: rtl/a_inv_apply_mat2_vec_mac.sv
// Two-stage 2x2 matrix-vector datapath: x = A * y with fixed-point A.
// Stage 1 registers the four 96-bit products; stage 2 sums each pair at
// 97 bits, rounds half up, shifts right by COEF_FRAC and saturates to 32 bits.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_en                advance enable (low = stall, every stage holds)
//   i_valid             a new vector enters stage 1 when i_en is high
//   i_a11..i_a22        coefficients applied to the entering vector
//   i_y1, i_y2          input vector
//   o_s1_valid          stage 1 holds a vector
//   o_valid, o_x1/o_x2  stage 2 result
module mat2_vec_mac
    import a_inv_apply_pkg::*;
#(
    parameter int unsigned COEF_FRAC = COEF_FRAC_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_valid,
    input  logic [COEF_W-1:0] i_a11,
    input  logic [COEF_W-1:0] i_a12,
    input  logic [COEF_W-1:0] i_a21,
    input  logic [COEF_W-1:0] i_a22,
    input  logic [VEC_W-1:0]  i_y1,
    input  logic [VEC_W-1:0]  i_y2,
    output logic              o_s1_valid,
    output logic              o_valid,
    output logic [VEC_W-1:0]  o_x1,
    output logic [VEC_W-1:0]  o_x2
);

    // Half an LSB of the result. With COEF_FRAC = 0 the shift amount wraps
    // to a huge value and the constant becomes zero, which is the right
    // (no rounding) behaviour.
    localparam logic signed [SUM_W-1:0] RND = SUM_W'(1) << (COEF_FRAC - 1);

    logic              r_s1_valid;
    logic [PROD_W-1:0] r_p11;
    logic [PROD_W-1:0] r_p12;
    logic [PROD_W-1:0] r_p21;
    logic [PROD_W-1:0] r_p22;

    logic              r_x_valid;
    logic [VEC_W-1:0]  r_x1;
    logic [VEC_W-1:0]  r_x2;

    logic signed [SUM_W-1:0] w_sum1;
    logic signed [SUM_W-1:0] w_sum2;
    logic signed [SUM_W-1:0] w_rnd1;
    logic signed [SUM_W-1:0] w_rnd2;
    logic signed [SUM_W-1:0] w_shr1;
    logic signed [SUM_W-1:0] w_shr2;

    // Stage 1: products.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_p11      <= '0;
            r_p12      <= '0;
            r_p21      <= '0;
            r_p22      <= '0;
        end else if (i_en) begin
            r_s1_valid <= i_valid;
            if (i_valid) begin
                r_p11 <= mul_cv(i_a11, i_y1);
                r_p12 <= mul_cv(i_a12, i_y2);
                r_p21 <= mul_cv(i_a21, i_y1);
                r_p22 <= mul_cv(i_a22, i_y2);
            end
        end
    end

    // Stage 2 combinational: widen by one bit so the pair sum cannot wrap.
    always_comb begin
        w_sum1 = {r_p11[PROD_W-1], r_p11} + {r_p12[PROD_W-1], r_p12};
        w_sum2 = {r_p21[PROD_W-1], r_p21} + {r_p22[PROD_W-1], r_p22};
        w_rnd1 = w_sum1 + RND;
        w_rnd2 = w_sum2 + RND;
        w_shr1 = w_rnd1 >>> COEF_FRAC;
        w_shr2 = w_rnd2 >>> COEF_FRAC;
    end

    // Stage 2: saturated result register; data only moves with a valid
    // vector so the outputs stay put between results.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_x_valid <= 1'b0;
            r_x1      <= '0;
            r_x2      <= '0;
        end else if (i_en) begin
            r_x_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_x1 <= sat_vec(w_shr1);
                r_x2 <= sat_vec(w_shr2);
            end
        end
    end

    assign o_s1_valid = r_s1_valid;
    assign o_valid    = r_x_valid;
    assign o_x1       = r_x1;
    assign o_x2       = r_x2;

endmodule

// File: rtl/a_inv_apply.sv
// Applies a 2x2 inverse matrix to a stream of signed 32-bit vectors.
// Holds an active coefficient set plus a shadow set; a new set received
// while running is parked in the shadow and swapped in only once the
// pipeline has drained, so every vector uses exactly one coefficient set.
// Ports:
//   I_sys_clk, I_sys_rst        clock, synchronous active-high reset
//   I_A11_inv..I_A22_inv        signed Q(64-COEF_FRAC).COEF_FRAC coefficients
//   I_A_inv_valid               coefficient set valid this cycle
//   I_y1, I_y2, I_y_valid       input vector, O_y_ready its ready
//   O_x1, O_x2, O_x_valid       result vector, I_x_ready its ready
//   O_vec_cnt                   results delivered since last activation
module a_inv_apply
    import a_inv_apply_pkg::*;
#(
    parameter int unsigned COEF_FRAC = COEF_FRAC_DEF
) (
    input  logic              I_sys_clk,
    input  logic              I_sys_rst,
    input  logic [COEF_W-1:0] I_A11_inv,
    input  logic [COEF_W-1:0] I_A12_inv,
    input  logic [COEF_W-1:0] I_A21_inv,
    input  logic [COEF_W-1:0] I_A22_inv,
    input  logic              I_A_inv_valid,
    input  logic [VEC_W-1:0]  I_y1,
    input  logic [VEC_W-1:0]  I_y2,
    input  logic              I_y_valid,
    output logic              O_y_ready,
    output logic [VEC_W-1:0]  O_x1,
    output logic [VEC_W-1:0]  O_x2,
    output logic              O_x_valid,
    input  logic              I_x_ready,
    output logic [CNT_W-1:0]  O_vec_cnt
);

    state_e           r_state;
    state_e           w_state_next;
    coef_t            r_act;
    coef_t            r_shd;
    coef_t            w_coef_in;
    logic [CNT_W-1:0] r_vec_cnt;

    logic w_stall;
    logic w_accept;
    logic w_xfer;
    logic w_s1_valid;
    logic w_x_valid;
    logic w_pipe_empty;
    logic w_load_act;
    logic w_load_shd;
    logic w_act_from_in;
    logic w_cnt_clr;

    assign w_coef_in = '{a11: I_A11_inv, a12: I_A12_inv, a21: I_A21_inv, a22: I_A22_inv};

    assign w_stall      = w_x_valid & ~I_x_ready;
    assign O_y_ready    = (r_state == S_RUN) & ~w_stall;
    assign w_accept     = I_y_valid & O_y_ready;
    assign w_xfer       = w_x_valid & I_x_ready;
    assign w_pipe_empty = ~w_s1_valid & ~w_x_valid;

    always_ff @(posedge I_sys_clk) begin
        if (I_sys_rst) begin
            r_state <= S_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_load_act    = 1'b0;
        w_load_shd    = 1'b0;
        w_act_from_in = 1'b0;
        w_cnt_clr     = 1'b0;
        unique case (r_state)
            S_EMPTY: begin
                if (I_A_inv_valid) begin
                    w_load_act    = 1'b1;
                    w_act_from_in = 1'b1;
                    w_cnt_clr     = 1'b1;
                    w_state_next  = S_RUN;
                end
            end
            S_RUN: begin
                if (I_A_inv_valid) begin
                    w_load_shd   = 1'b1;
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pipe_empty) begin
                    // A set arriving in the swap cycle is the newest one, so
                    // it goes straight to active instead of via the shadow.
                    w_load_act    = 1'b1;
                    w_act_from_in = I_A_inv_valid;
                    w_cnt_clr     = 1'b1;
                    w_state_next  = S_RUN;
                end else if (I_A_inv_valid) begin
                    w_load_shd = 1'b1;
                end
            end
            default: begin
                w_state_next = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge I_sys_clk) begin
        if (I_sys_rst) begin
            r_act <= '0;
            r_shd <= '0;
        end else begin
            if (w_load_act) begin
                r_act <= w_act_from_in ? w_coef_in : r_shd;
            end
            if (w_load_shd) begin
                r_shd <= w_coef_in;
            end
        end
    end

    always_ff @(posedge I_sys_clk) begin
        if (I_sys_rst) begin
            r_vec_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_vec_cnt <= '0;
        end else if (w_xfer) begin
            r_vec_cnt <= r_vec_cnt + 1'b1;
        end
    end

    assign O_vec_cnt = r_vec_cnt;
    assign O_x_valid = w_x_valid;

    mat2_vec_mac #(
        .COEF_FRAC (COEF_FRAC)
    ) u_mac (
        .i_clk      (I_sys_clk),
        .i_rst      (I_sys_rst),
        .i_en       (~w_stall),
        .i_valid    (w_accept),
        .i_a11      (r_act.a11),
        .i_a12      (r_act.a12),
        .i_a21      (r_act.a21),
        .i_a22      (r_act.a22),
        .i_y1       (I_y1),
        .i_y2       (I_y2),
        .o_s1_valid (w_s1_valid),
        .o_valid    (w_x_valid),
        .o_x1       (O_x1),
        .o_x2       (O_x2)
    );

endmodule
